rds_block_encoder: RTL and testbench

Builds the circular RDS message consumed by the `rds` mixer. Takes 16-bit RDS information words with an offset tag, appends the 10-bit CRC checkword plus offset, and packs the resulting 26-bit blocks MSB-first into bytes. It writes those bytes sequentially into the message RAM (`bram_rds`) that `rds` reads at 1187.5 bit/s. It replaces the static message image with one that can be regenerated at run time (PS name, RadioText updates).

---
 rtl/rds_pkg.sv | 38 +++
 rtl/rds_crc10.sv | 22 ++
 rtl/rds_block_encoder.sv | 139 +++++++++++++
 tb/tb_rds_block_encoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rds_pkg.sv
// Shared RDS constants: CRC generator, offset words, offset-tag and FSM encodings.
package rds_pkg;

  localparam logic [10:0] CRC_POLY    = 11'h5B9;
  localparam int          GROUP_BYTES = 13;

  localparam logic [9:0] OFS_A  = 10'h0FC;
  localparam logic [9:0] OFS_B  = 10'h198;
  localparam logic [9:0] OFS_C  = 10'h168;
  localparam logic [9:0] OFS_CP = 10'h350;
  localparam logic [9:0] OFS_D  = 10'h1B4;

  typedef enum logic [2:0] {
    TAG_A  = 3'd0,
    TAG_B  = 3'd1,
    TAG_C  = 3'd2,
    TAG_CP = 3'd3,
    TAG_D  = 3'd4
  } ofs_tag_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CRC  = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Tags 5..7 fall through to D.
  function automatic logic [9:0] offset_word(input logic [2:0] tag);
    case (tag)
      TAG_A:   return OFS_A;
      TAG_B:   return OFS_B;
      TAG_C:   return OFS_C;
      TAG_CP:  return OFS_CP;
      default: return OFS_D;
    endcase
  endfunction

endpackage

// File: rtl/rds_crc10.sv
// Serial MSB-first LFSR divider; rem holds data*x^10 mod g(x) after 16 shifts.
module rds_crc10
  import rds_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [9:0] rem
);

  logic fb;
  assign fb = din ^ rem[9];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rem <= '0;
    else if (clr) rem <= '0;
    else if (en)  rem <= {rem[8:0], 1'b0} ^ ({10{fb}} & CRC_POLY[9:0]);
  end

endmodule

// File: rtl/rds_block_encoder.sv
// Turns tagged 16-bit RDS info words into 26-bit blocks and streams them as
// MSB-first bytes into the circular message RAM.
module rds_block_encoder
  import rds_pkg::*;
#(
  parameter int C_MSG_LEN = 260
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        word_valid,
  output logic        word_ready,
  input  logic [15:0] word_data,
  input  logic [2:0]  word_offset,
  output logic        wr_en,
  output logic [8:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        group_done
);

  state_e      state, state_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [15:0] data_q;
  logic [2:0]  ofs_q;
  logic [7:0]  byte_sh;
  logic [2:0]  bit_cnt;
  logic [8:0]  addr_q;
  logic [3:0]  grp_q;
  logic        take, crc_clr, crc_en, emit;
  logic [9:0]  rem;
  logic [25:0] block;
  logic        bit_out;
  logic [7:0]  byte_nxt;

  rds_crc10 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (data_q[~cnt[3:0]]),
    .rem   (rem)
  );

  // rem is stable throughout EMIT, so the checkword is formed combinationally.
  assign block    = {data_q, rem ^ offset_word(ofs_q)};
  assign bit_out  = block[5'd25 - cnt];
  assign byte_nxt = {byte_sh[6:0], bit_out};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    emit      = 1'b0;
    case (state)
      ST_IDLE: if (word_valid && word_ready) begin
        take      = 1'b1;
        crc_clr   = 1'b1;
        state_nxt = ST_CRC;
        cnt_nxt   = '0;
      end
      ST_CRC: begin
        crc_en  = 1'b1;
        cnt_nxt = cnt + 5'd1;
        if (cnt == 5'd15) begin
          state_nxt = ST_EMIT;
          cnt_nxt   = '0;
        end
      end
      ST_EMIT: begin
        emit    = 1'b1;
        cnt_nxt = cnt + 5'd1;
        if (cnt == 5'd25) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (restart) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      take      = 1'b0;
      crc_clr   = 1'b0;
      crc_en    = 1'b0;
      emit      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      data_q     <= '0;
      ofs_q      <= '0;
      byte_sh    <= '0;
      bit_cnt    <= '0;
      addr_q     <= '0;
      grp_q      <= '0;
      word_ready <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      group_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      word_ready <= (state_nxt == ST_IDLE);
      wr_en      <= 1'b0;
      group_done <= 1'b0;
      if (take) begin
        data_q <= word_data;
        ofs_q  <= word_offset;
      end
      if (restart) begin
        bit_cnt <= '0;
        addr_q  <= '0;
        grp_q   <= '0;
      end else if (emit) begin
        byte_sh <= byte_nxt;
        bit_cnt <= bit_cnt + 3'd1;
        // Bit count carries across blocks, so a byte may straddle two words.
        if (bit_cnt == 3'd7) begin
          wr_en      <= 1'b1;
          wr_data    <= byte_nxt;
          wr_addr    <= addr_q;
          group_done <= (grp_q == 4'(GROUP_BYTES - 1));
          grp_q      <= (grp_q == 4'(GROUP_BYTES - 1)) ? 4'd0 : grp_q + 4'd1;
          addr_q     <= (addr_q == 9'(C_MSG_LEN - 1)) ? 9'd0 : addr_q + 9'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rds_block_encoder.sv
// Scoreboard bench: stimulus pushes expected RAM writes, a monitor pops them.
module tb_rds_block_encoder;

  localparam int C_MSG_LEN = 260;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        word_valid = 1'b0;
  logic [15:0] word_data = '0;
  logic [2:0]  word_offset = '0;
  logic        word_ready, wr_en, group_done;
  logic [8:0]  wr_addr;
  logic [7:0]  wr_data;

  rds_block_encoder #(.C_MSG_LEN(C_MSG_LEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart     (restart),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word_data   (word_data),
    .word_offset (word_offset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .group_done  (group_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
    logic       gd;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk = 0;
  int  n_pass = 0;
  int  n_wr = 0;

  // bench-side model of the packer
  int         m_addr = 0;
  int         m_nbits = 0;
  logic [7:0] m_byte = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst_n && wr_en) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got addr %0d data 0x%02h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
        chk("group_done", 32'(group_done), 32'(e.gd));
      end
    end else if (rst_n && group_done) begin
      n_chk++;
      $display("FAIL group_done_alone: got 1 without wr_en, expected 0");
    end
  end

  function automatic logic [9:0] ofs_const(input logic [2:0] tag);
    case (tag)
      3'd0: return 10'h0FC;
      3'd1: return 10'h198;
      3'd2: return 10'h168;
      3'd3: return 10'h350;
      default: return 10'h1B4;
    endcase
  endfunction

  // Long division of d*x^10 by 0x5B9.
  function automatic logic [9:0] crc_model(input logic [15:0] d);
    logic [25:0] r;
    r = {d, 10'b0};
    for (int i = 25; i >= 10; i--)
      if (r[i]) r = r ^ (26'h5B9 << (i - 10));
    return r[9:0];
  endfunction

  task automatic push_exp(input int a, input logic [7:0] d, input logic gd);
    wr_t e;
    e.addr = 9'(a);
    e.data = d;
    e.gd   = gd;
    exp_q.push_back(e);
  endtask

  task automatic model_word(input logic [15:0] d, input logic [2:0] tag);
    logic [25:0] blk;
    blk = {d, crc_model(d) ^ ofs_const(tag)};
    for (int i = 25; i >= 0; i--) begin
      m_byte = {m_byte[6:0], blk[i]};
      m_nbits++;
      if (m_nbits == 8) begin
        push_exp(m_addr, m_byte, ((m_addr + 1) % 13) == 0);
        m_addr  = (m_addr == C_MSG_LEN - 1) ? 0 : m_addr + 1;
        m_nbits = 0;
      end
    end
  endtask

  task automatic model_reset();
    m_addr  = 0;
    m_nbits = 0;
    m_byte  = '0;
  endtask

  // Returns one cycle after the handshake edge, at posedge+1.
  task automatic send(input logic [15:0] d, input logic [2:0] tag, input bit use_model);
    int t;
    t = 0;
    while (!word_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      n_chk++;
      $display("FAIL ready_timeout: got word_ready 0 for 200 cycles, expected 1");
    end
    if (use_model) model_word(d, tag);
    word_valid  = 1'b1;
    word_data   = d;
    word_offset = tag;
    @(posedge clk); #1;
    word_valid  = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    model_reset();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_word_ready"}, 32'(word_ready), 32'd1);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_group_done"}, 32'(group_done), 32'd0);
  endtask

  initial begin
    int wr0;
    logic [2:0] tags[4];

    idle(2);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle(1);

    // zero word, offset A: block 0x00000FC
    push_exp(0, 8'h00, 1'b0);
    push_exp(1, 8'h00, 1'b0);
    push_exp(2, 8'h3F, 1'b0);
    send(16'h0000, 3'd0, 1'b0);
    chk("ready_c1", 32'(word_ready), 32'd0);
    idle(41);
    chk("ready_c42", 32'(word_ready), 32'd0);
    idle(1);
    chk("ready_c43", 32'(word_ready), 32'd1);
    idle(10);
    chk("zeroA_bit_cnt", 32'(dut.bit_cnt), 32'd2);
    chk("zeroA_drained", 32'(exp_q.size()), 32'd0);

    // 0x0001, offset A: block 0x0000545
    do_restart();
    push_exp(0, 8'h00, 1'b0);
    push_exp(1, 8'h01, 1'b0);
    push_exp(2, 8'h51, 1'b0);
    send(16'h0001, 3'd0, 1'b0);
    idle(50);
    chk("one_bit_cnt", 32'(dut.bit_cnt), 32'd2);
    chk("one_pending", 32'(dut.byte_sh[1:0]), 32'd1);
    chk("one_drained", 32'(exp_q.size()), 32'd0);

    // one full group of zero words
    do_restart();
    send(16'h0000, 3'd0, 1'b1);
    send(16'h0000, 3'd1, 1'b1);
    send(16'h0000, 3'd2, 1'b1);
    send(16'h0000, 3'd4, 1'b1);
    idle(50);
    chk("group_addr", 32'(dut.addr_q), 32'd13);
    chk("group_bit_cnt", 32'(dut.bit_cnt), 32'd0);
    chk("group_drained", 32'(exp_q.size()), 32'd0);

    // 20 random groups fill the whole message, then one more word wraps
    do_restart();
    wr0 = n_wr;
    for (int g = 0; g < 20; g++) begin
      tags[0] = 3'd0;
      tags[1] = 3'd1;
      tags[2] = ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd3;
      tags[3] = 3'(4 + $urandom_range(0, 3) % 4);
      if (tags[3] > 3'd7) tags[3] = 3'd4;
      for (int w = 0; w < 4; w++) send(16'($urandom), tags[w], 1'b1);
    end
    idle(50);
    chk("full_msg_writes", 32'(n_wr - wr0), 32'd260);
    chk("full_msg_drained", 32'(exp_q.size()), 32'd0);
    send(16'h0000, 3'd0, 1'b1);
    idle(50);
    chk("wrap_drained", 32'(exp_q.size()), 32'd0);

    // restart in cycle 20 with a competing handshake
    do_restart();
    send(16'h0000, 3'd0, 1'b0);
    idle(19);
    restart     = 1'b1;
    word_valid  = 1'b1;
    word_data   = 16'hFFFF;
    word_offset = 3'd1;
    idle(1);
    restart    = 1'b0;
    word_valid = 1'b0;
    model_reset();
    chk("restart_ready", 32'(word_ready), 32'd1);
    chk("restart_bit_cnt", 32'(dut.bit_cnt), 32'd0);
    idle(1);
    chk("restart_not_taken", 32'(word_ready), 32'd1);
    idle(60);
    push_exp(0, 8'h00, 1'b0);
    push_exp(1, 8'h00, 1'b0);
    push_exp(2, 8'h3F, 1'b0);
    send(16'h0000, 3'd0, 1'b0);
    idle(50);
    chk("after_restart_drained", 32'(exp_q.size()), 32'd0);

    // asynchronous reset pulse mid-EMIT, after the first byte went out
    do_restart();
    push_exp(0, 8'h00, 1'b0);
    send(16'h0000, 3'd0, 1'b0);
    idle(29);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    #2;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    idle(60);
    chk("async_drained", 32'(exp_q.size()), 32'd0);
    chk("async_ready", 32'(word_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
